pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the five-stage MIPS pipeline.
- Decides each cycle whether the PC and IF/ID hold, and which pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) load a bubble.
- Inputs: Tuse/Tnew register hazards, the multi-cycle HI/LO multiply/divide unit, and exception/eret requests raised at MEM by CP0.
- Owns the mult/div busy countdown, so it is the sole authority on when an HI/LO instruction may leave ID.

Parameters:
MULT_CYCLES, 5, busy cycles after a mult/multu issues from EX
DIV_CYCLES, 10, busy cycles after a div/divu issues from EX
CNT_W, 4, counter width; must hold max(MULT_CYCLES, DIV_CYCLES)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
id_rs  input  5  rs address of instruction in ID
id_rt  input  5  rt address of instruction in ID
id_tuse_rs  input  2  cycles until rs is needed (0/1; 3 = not used)
id_tuse_rt  input  2  cycles until rt is needed (0/1/2; 3 = not used)
id_is_md  input  1  ID instruction is mult/div/mfhi/mflo/mthi/mtlo
ex_wa  input  5  GRF write address of instruction in EX
ex_tnew  input  2  cycles until EX result is available
mem_wa  input  5  GRF write address of instruction in MEM
mem_tnew  input  2  cycles until MEM result is available
ex_md_start  input  1  mult/div is in EX this cycle
ex_md_div  input  1  1 = divide, 0 = multiply (valid with ex_md_start)
exc_req  input  1  CP0 takes interrupt/exception on MEM instruction
mem_eret  input  1  eret in MEM
pc_en  output  1  PC load enable
ifid_en  output  1  IF/ID load enable
ifid_clr  output  1  IF/ID loads zero
idex_clr  output  1  ID/EX loads zero (bubble)
exme_clr  output  1  EX/MEM loads zero
mewb_clr  output  1  MEM/WB loads zero
pc_sel  output  2  0 = PC+4/branch, 1 = handler 0x0000_4180, 2 = EPC
md_busy  output  1  HI/LO unit busy

Behaviour:
- Reset (async):
  - md_cnt=0, md_state=IDLE.
  - With all inputs 0, outputs are pc_en=1, ifid_en=1, all clr=0, pc_sel=0, md_busy=0.
- Register hazard (combinational):
  - hz_rs = id_rs!=0 && ((id_rs==ex_wa && id_tuse_rs<ex_tnew) || (id_rs==mem_wa && id_tuse_rs<mem_tnew)).
  - hz_rt is the same with id_rt and id_tuse_rt.
  - Tnew/Tuse compare unsigned.
- md FSM, states IDLE and BUSY:
  - md_go = ex_md_start & ~exc_req & ~mem_eret.
  - IDLE --md_go--> BUSY, loading md_cnt = (ex_md_div ? DIV_CYCLES : MULT_CYCLES) - 1.
  - BUSY: md_cnt decrements each cycle; at md_cnt==0 → IDLE.
  - md_go while BUSY cannot occur, because ID stalls. If it does, reload anyway.
  - exc_req never aborts a BUSY count; the operation is committed.
  - md_busy = (state==BUSY) | md_go.
- hz_md = id_is_md & md_busy.
- stall = hz_rs | hz_rt | hz_md.
- Priority 1, exc_req:
  - pc_sel=1, pc_en=1, ifid_en=1.
  - ifid_clr, idex_clr, exme_clr, mewb_clr all 1.
- Priority 2, mem_eret (exc_req=0):
  - pc_sel=2, pc_en=1, ifid_en=1.
  - ifid_clr, idex_clr, exme_clr all 1; mewb_clr=0 (eret itself writes nothing).
- Priority 3, stall: pc_en=0, ifid_en=0, idex_clr=1, other clr=0, pc_sel=0.
- Otherwise: pc_en=1, ifid_en=1, all clr=0, pc_sel=0.
- Latency:
  - Control outputs are combinational in the same cycle as their inputs.
  - md_busy persists exactly N cycles after the cycle in which md_go=1 (N = MULT_CYCLES or DIV_CYCLES); md_go cycle counts as cycle 1.
- Reset mid-count forces IDLE immediately, regardless of clk.

Decomposition:
- Shared package cpu_defs:
  - TUSE_NONE=2'd3.
  - PC_SEL_NPC/PC_SEL_EXC/PC_SEL_EPC.
  - EXC_HANDLER=32'h0000_4180.
  - MULT_CYCLES, DIV_CYCLES.
- One sub-module, md_busy_ctr: the FSM plus counter, exposing md_go, md_div, busy.
- The hazard/priority logic stays in the top module.

Test Plan:
- ex_wa=8, ex_tnew=2, id_rs=8, id_tuse_rs=0 (lw→beq) → pc_en=0, ifid_en=0, idex_clr=1. With ex_tnew=0 instead → no stall.
- id_rs=0 with ex_wa=0, ex_tnew=2 → no stall. Checks that $zero is never a hazard.
- ex_md_start=1, ex_md_div=0 at cycle t, id_is_md=1 from t → md_busy high t..t+4, stall t..t+4, pc_en=1 at t+5. Repeat with div → busy t..t+9.
- ex_md_start=1 and exc_req=1 in the same cycle → md_busy=0 next cycle. pc_sel=1 and all four clr=1 in that cycle.
- exc_req=1 together with hz_rs stall and mem_eret → pc_sel=1, pc_en=1, ifid_en=1, mewb_clr=1. Checks exception priority.
- Assert reset at md_cnt=3 in BUSY → md_busy=0 asynchronously. After release, id_is_md=1 does not stall.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared CPU definitions for the pipeline control slice: PC source selects,
// Tuse encoding, exception vector and HI/LO unit latencies.
package cpu_defs;

    localparam logic [1:0]  TUSE_NONE   = 2'd3;
    localparam logic [31:0] EXC_HANDLER = 32'h0000_4180;
    localparam int unsigned MULT_CYCLES = 5;
    localparam int unsigned DIV_CYCLES  = 10;

    typedef enum logic [1:0] {
        PC_SEL_NPC = 2'd0,
        PC_SEL_EXC = 2'd1,
        PC_SEL_EPC = 2'd2
    } pc_sel_e;

    typedef enum logic {
        MD_IDLE,
        MD_BUSY
    } md_state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline hazard/exception inputs and the
// resulting stall/flush controls. The CPU datapath is master, controller is slave.
interface pipe_hazard_ctrl_if;

    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic [1:0] id_tuse_rs;
    logic [1:0] id_tuse_rt;
    logic       id_is_md;
    logic [4:0] ex_wa;
    logic [1:0] ex_tnew;
    logic [4:0] mem_wa;
    logic [1:0] mem_tnew;
    logic       ex_md_start;
    logic       ex_md_div;
    logic       exc_req;
    logic       mem_eret;

    logic       pc_en;
    logic       ifid_en;
    logic       ifid_clr;
    logic       idex_clr;
    logic       exme_clr;
    logic       mewb_clr;
    logic [1:0] pc_sel;
    logic       md_busy;

    modport master (
        output id_rs, id_rt, id_tuse_rs, id_tuse_rt, id_is_md,
               ex_wa, ex_tnew, mem_wa, mem_tnew,
               ex_md_start, ex_md_div, exc_req, mem_eret,
        input  pc_en, ifid_en, ifid_clr, idex_clr, exme_clr, mewb_clr,
               pc_sel, md_busy
    );

    modport slave (
        input  id_rs, id_rt, id_tuse_rs, id_tuse_rt, id_is_md,
               ex_wa, ex_tnew, mem_wa, mem_tnew,
               ex_md_start, ex_md_div, exc_req, mem_eret,
        output pc_en, ifid_en, ifid_clr, idex_clr, exme_clr, mewb_clr,
               pc_sel, md_busy
    );

endinterface

// File: rtl/pipe_hazard_ctrl_md.sv
// HI/LO unit busy tracker: IDLE/BUSY FSM with a countdown loaded when a
// mult/div issues from EX.
module md_busy_ctr
    import cpu_defs::*;
#(
    parameter int unsigned MULT_CYCLES = cpu_defs::MULT_CYCLES,
    parameter int unsigned DIV_CYCLES  = cpu_defs::DIV_CYCLES,
    parameter int unsigned CNT_W       = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic md_go,
    input  logic md_div,
    output logic busy
);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    md_state_e        state, state_next;
    logic [CNT_W-1:0] md_cnt, cnt_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= MD_IDLE;
            md_cnt <= '0;
        end else begin
            state  <= state_next;
            md_cnt <= cnt_next;
        end
    end

    // The go cycle is busy cycle 1, so the register only needs N-1 BUSY cycles;
    // leave BUSY on the edge where the count reaches zero.
    always_comb begin
        state_next = state;
        cnt_next   = md_cnt;
        if (md_go) begin
            cnt_next   = md_div ? DIV_LOAD : MULT_LOAD;
            state_next = (cnt_next == '0) ? MD_IDLE : MD_BUSY;
        end else if (state == MD_BUSY) begin
            cnt_next = md_cnt - 1'b1;
            if (cnt_next == '0) begin
                state_next = MD_IDLE;
            end
        end
    end

    assign busy = (state == MD_BUSY) | md_go;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the five-stage pipeline: Tuse/Tnew
// register hazards, HI/LO busy interlock and CP0 exception/eret redirect.
module pipe_hazard_ctrl
    import cpu_defs::*;
#(
    parameter int unsigned MULT_CYCLES = cpu_defs::MULT_CYCLES,
    parameter int unsigned DIV_CYCLES  = cpu_defs::DIV_CYCLES,
    parameter int unsigned CNT_W       = 4
) (
    input  logic               clk,
    input  logic               reset,
    pipe_hazard_ctrl_if.slave  bus
);

    logic md_go;
    logic md_busy;
    logic hz_rs, hz_rt, hz_md, stall;
    pc_sel_e pc_sel;

    // An op whose EX cycle is being flushed never starts the unit.
    assign md_go = bus.ex_md_start & ~bus.exc_req & ~bus.mem_eret;

    md_busy_ctr #(
        .MULT_CYCLES(MULT_CYCLES),
        .DIV_CYCLES (DIV_CYCLES),
        .CNT_W      (CNT_W)
    ) u_md (
        .clk   (clk),
        .reset (reset),
        .md_go (md_go),
        .md_div(bus.ex_md_div),
        .busy  (md_busy)
    );

    assign hz_rs = (bus.id_rs != 5'd0) &&
                   (((bus.id_rs == bus.ex_wa)  && (bus.id_tuse_rs < bus.ex_tnew)) ||
                    ((bus.id_rs == bus.mem_wa) && (bus.id_tuse_rs < bus.mem_tnew)));
    assign hz_rt = (bus.id_rt != 5'd0) &&
                   (((bus.id_rt == bus.ex_wa)  && (bus.id_tuse_rt < bus.ex_tnew)) ||
                    ((bus.id_rt == bus.mem_wa) && (bus.id_tuse_rt < bus.mem_tnew)));
    assign hz_md = bus.id_is_md & md_busy;
    assign stall = hz_rs | hz_rt | hz_md;

    always_comb begin
        bus.pc_en    = 1'b1;
        bus.ifid_en  = 1'b1;
        bus.ifid_clr = 1'b0;
        bus.idex_clr = 1'b0;
        bus.exme_clr = 1'b0;
        bus.mewb_clr = 1'b0;
        pc_sel       = PC_SEL_NPC;
        if (bus.exc_req) begin
            pc_sel       = PC_SEL_EXC;
            bus.ifid_clr = 1'b1;
            bus.idex_clr = 1'b1;
            bus.exme_clr = 1'b1;
            bus.mewb_clr = 1'b1;
        end else if (bus.mem_eret) begin
            pc_sel       = PC_SEL_EPC;
            bus.ifid_clr = 1'b1;
            bus.idex_clr = 1'b1;
            bus.exme_clr = 1'b1;
        end else if (stall) begin
            bus.pc_en    = 1'b0;
            bus.ifid_en  = 1'b0;
            bus.idex_clr = 1'b1;
        end
    end

    assign bus.pc_sel  = pc_sel;
    assign bus.md_busy = md_busy;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;
  import cpu_defs::*;

  typedef struct packed {
    logic       pc_en;
    logic       ifid_en;
    logic       ifid_clr;
    logic       idex_clr;
    logic       exme_clr;
    logic       mewb_clr;
    logic [1:0] pc_sel;
    logic       md_busy;
  } ctl_t;

  logic clk = 1'b0;
  logic reset;
  pipe_hazard_ctrl_if bus();

  pipe_hazard_ctrl #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10),
    .CNT_W      (4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  ctl_t  exp_q[$];
  string tag_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    cyc     = 0;
  int    busy_end = 0;

  task automatic zero_in();
    bus.id_rs = '0; bus.id_rt = '0;
    bus.id_tuse_rs = TUSE_NONE; bus.id_tuse_rt = TUSE_NONE;
    bus.id_is_md = 1'b0;
    bus.ex_wa = '0; bus.ex_tnew = '0; bus.mem_wa = '0; bus.mem_tnew = '0;
    bus.ex_md_start = 1'b0; bus.ex_md_div = 1'b0;
    bus.exc_req = 1'b0; bus.mem_eret = 1'b0;
  endtask

  function automatic bit reg_hz(input logic [4:0] r, input logic [1:0] tuse);
    int t = int'(tuse);
    if (r == 0) return 0;
    if (r == bus.ex_wa && t < int'(bus.ex_tnew)) return 1;
    if (r == bus.mem_wa && t < int'(bus.mem_tnew)) return 1;
    return 0;
  endfunction

  task automatic step(input string tag);
    ctl_t e;
    bit go, busy, stall;
    go    = bus.ex_md_start && !bus.exc_req && !bus.mem_eret && !reset;
    busy  = (cyc < busy_end) || go;
    stall = reg_hz(bus.id_rs, bus.id_tuse_rs) || reg_hz(bus.id_rt, bus.id_tuse_rt) ||
            (bus.id_is_md && busy);
    e = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_clr: 1'b0, idex_clr: 1'b0,
          exme_clr: 1'b0, mewb_clr: 1'b0, pc_sel: 2'd0, md_busy: busy};
    if (bus.exc_req) begin
      e.pc_sel = 2'd1; e.ifid_clr = 1; e.idex_clr = 1; e.exme_clr = 1; e.mewb_clr = 1;
    end else if (bus.mem_eret) begin
      e.pc_sel = 2'd2; e.ifid_clr = 1; e.idex_clr = 1; e.exme_clr = 1;
    end else if (stall) begin
      e.pc_en = 0; e.ifid_en = 0; e.idex_clr = 1;
    end
    exp_q.push_back(e);
    tag_q.push_back(tag);
    if (go) busy_end = cyc + (bus.ex_md_div ? 10 : 5);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic rand_in();
    bus.id_rs       = 5'($urandom_range(0, 3));
    bus.id_rt       = 5'($urandom_range(0, 3));
    bus.id_tuse_rs  = ($urandom_range(0, 2) == 2) ? TUSE_NONE : 2'($urandom_range(0, 1));
    bus.id_tuse_rt  = 2'($urandom_range(0, 3));
    bus.id_is_md    = ($urandom_range(0, 2) == 0);
    bus.ex_wa       = 5'($urandom_range(0, 3));
    bus.ex_tnew     = 2'($urandom_range(0, 3));
    bus.mem_wa      = 5'($urandom_range(0, 3));
    bus.mem_tnew    = 2'($urandom_range(0, 3));
    bus.ex_md_start = ($urandom_range(0, 7) == 0);
    bus.ex_md_div   = 1'($urandom_range(0, 1));
    bus.exc_req     = ($urandom_range(0, 15) == 0);
    bus.mem_eret    = ($urandom_range(0, 15) == 0);
  endtask

  initial begin : monitor
    ctl_t  e, act;
    string t;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        act = '{pc_en: bus.pc_en, ifid_en: bus.ifid_en, ifid_clr: bus.ifid_clr,
                idex_clr: bus.idex_clr, exme_clr: bus.exme_clr,
                mewb_clr: bus.mewb_clr, pc_sel: bus.pc_sel, md_busy: bus.md_busy};
        n_tests++;
        if (act !== e) begin
          n_fail++;
          $display("FAIL %s cyc=%0d: got {pc_en,ifid_en,ifid_clr,idex_clr,exme_clr,mewb_clr,pc_sel,md_busy}=%b expected %b",
                   t, cyc, act, e);
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    reset = 1'b1;
    zero_in();
    @(posedge clk);
    #1;
    step("reset_state");
    reset = 1'b0;
    step("idle_nominal");

    bus.ex_wa = 5'd8; bus.ex_tnew = 2'd2; bus.id_rs = 5'd8; bus.id_tuse_rs = 2'd0;
    #1;
    n_tests++;
    if (bus.pc_en !== 1'b0) begin
      n_fail++;
      $display("FAIL direct lw_beq_stall: pc_en=%b expected 0", bus.pc_en);
    end
    n_tests++;
    if (bus.ifid_en !== 1'b0) begin
      n_fail++;
      $display("FAIL direct lw_beq_stall: ifid_en=%b expected 0", bus.ifid_en);
    end
    n_tests++;
    if (bus.idex_clr !== 1'b1) begin
      n_fail++;
      $display("FAIL direct lw_beq_stall: idex_clr=%b expected 1", bus.idex_clr);
    end
    step("lw_beq_stall");
    bus.ex_tnew = 2'd0;
    step("lw_beq_ready");
    zero_in();
    bus.ex_wa = 5'd0; bus.ex_tnew = 2'd2; bus.id_rs = 5'd0; bus.id_tuse_rs = 2'd0;
    #1;
    n_tests++;
    if (bus.pc_en !== 1'b1) begin
      n_fail++;
      $display("FAIL direct zero_reg: pc_en=%b expected 1", bus.pc_en);
    end
    step("zero_reg");
    zero_in();
    bus.mem_wa = 5'd5; bus.mem_tnew = 2'd2; bus.id_rt = 5'd5; bus.id_tuse_rt = 2'd1;
    step("rt_mem_stall");

    zero_in();
    bus.id_is_md = 1'b1; bus.ex_md_start = 1'b1; bus.ex_md_div = 1'b0;
    step("mult_go");
    bus.ex_md_start = 1'b0;
    for (int unsigned i = 0; i < 6; i++) step("mult_busy");
    bus.ex_md_start = 1'b1; bus.ex_md_div = 1'b1;
    step("div_go");
    bus.ex_md_start = 1'b0;
    for (int unsigned i = 0; i < 11; i++) step("div_busy");

    zero_in();
    bus.ex_md_start = 1'b1; bus.exc_req = 1'b1;
    #1;
    n_tests++;
    if (bus.pc_sel !== 2'd1) begin
      n_fail++;
      $display("FAIL direct md_exc_same: pc_sel=%0d expected 1", bus.pc_sel);
    end
    step("md_exc_same");
    zero_in();
    bus.id_is_md = 1'b1;
    step("md_exc_next");

    zero_in();
    bus.ex_wa = 5'd3; bus.ex_tnew = 2'd2; bus.id_rs = 5'd3; bus.id_tuse_rs = 2'd0;
    bus.exc_req = 1'b1; bus.mem_eret = 1'b1;
    #1;
    n_tests++;
    if (bus.mewb_clr !== 1'b1) begin
      n_fail++;
      $display("FAIL direct exc_priority: mewb_clr=%b expected 1", bus.mewb_clr);
    end
    n_tests++;
    if (bus.pc_en !== 1'b1) begin
      n_fail++;
      $display("FAIL direct exc_priority: pc_en=%b expected 1", bus.pc_en);
    end
    step("exc_priority");
    bus.exc_req = 1'b0;
    step("eret_priority");

    zero_in();
    bus.ex_md_start = 1'b1;
    step("mid_go");
    bus.ex_md_start = 1'b0;
    step("mid_busy");
    reset = 1'b1;
    busy_end = 0;
    bus.id_is_md = 1'b1;
    #1;
    n_tests++;
    if (bus.md_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL direct mid_reset: md_busy=%b expected 0", bus.md_busy);
    end
    step("mid_reset");
    reset = 1'b0;
    step("after_reset_md");

    for (int unsigned i = 0; i < 600; i++) begin
      rand_in();
      step("random");
    end
    zero_in();
    step("final_idle");
    @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
